// File: rtl/sdi_timing_analyzer.sv
// SDI timing analyzer: TRS decode from raw luma, H/V/F regeneration, 4:2:2 demux, raster measurement and lock.
// Video and syncs lag the inputs by a fixed 2 cycles; no backpressure, one sample accepted every cycle.
module sdi_timing_analyzer #(
    parameter int DW          = 10,
    parameter int IMG_W       = 1920,
    parameter int IMG_H       = 540,
    parameter int CNT_W       = 12,
    parameter int LOCK_FIELDS = 2,
    parameter int ERR_FIELDS  = 2,
    parameter int TRS_TIMEOUT = 8192
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DW-1:0]    i_y,
    input  logic [DW-1:0]    i_cbcr,
    output logic             o_sync_h,
    output logic             o_sync_v,
    output logic             o_field,
    output logic [DW-1:0]    o_y,
    output logic [DW-1:0]    o_cb,
    output logic [DW-1:0]    o_cr,
    output logic [CNT_W-1:0] o_line_len,
    output logic [CNT_W-1:0] o_field_lines,
    output logic             o_locked,
    output logic [7:0]       o_err_count
);

    localparam int TO_W = $clog2(TRS_TIMEOUT);
    localparam logic [DW-1:0]    ALL1     = {DW{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] W_EXP    = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] H_EXP    = CNT_W'(IMG_H);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TRS_TIMEOUT - 1);
    localparam logic [7:0]       LOCK_N   = 8'(LOCK_FIELDS);
    localparam logic [7:0]       ERR_N    = 8'(ERR_FIELDS);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic [DW-1:0]    hist0;
    logic [DW-1:0]    hist1;
    logic [DW-1:0]    hist2;
    logic [TO_W-1:0]  to_cnt;
    logic             meas;
    logic [CNT_W-1:0] len_cnt;
    logic             bad_line;
    logic [CNT_W-1:0] line_cnt;
    logic             act_lines;
    logic             field_f;
    logic             s1_h;
    logic [DW-1:0]    s1_y;
    logic [DW-1:0]    s1_cb;
    logic [DW-1:0]    s1_cr;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] good_cnt;
    logic [7:0] good_nxt;
    logic [7:0] bad_cnt;
    logic [7:0] bad_nxt;
    logic [7:0] err_nxt;

    logic xyz_seen;
    logic xyz_ok;
    logic xyz_f;
    logic xyz_v;
    logic xyz_h;
    logic sav;
    logic eav;
    logic is_ones;
    logic timeout;
    logic field_end;
    logic field_good;
    logic active_in;

    assign xyz_seen  = (hist2 == ALL1) && (hist1 == '0) && (hist0 == '0);
    assign xyz_ok    = xyz_seen && i_y[DW-1];
    assign xyz_f     = i_y[DW-2];
    assign xyz_v     = i_y[DW-3];
    assign xyz_h     = i_y[DW-4];
    assign sav       = xyz_ok && !xyz_h;
    assign eav       = xyz_ok && xyz_h;
    assign is_ones   = (i_y == ALL1);
    assign timeout   = !xyz_ok && (to_cnt == TO_LAST);
    assign field_end = xyz_ok && xyz_v && act_lines && !timeout;
    assign field_good = (line_cnt == H_EXP) && !bad_line;

    // Window runs IMG_W samples but is cut short by any all-ones word (the next EAV preamble).
    assign active_in = meas && !is_ones && (len_cnt < W_EXP) && !timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hist0         <= '0;
            hist1         <= '0;
            hist2         <= '0;
            to_cnt        <= '0;
            meas          <= 1'b0;
            len_cnt       <= '0;
            bad_line      <= 1'b0;
            line_cnt      <= '0;
            act_lines     <= 1'b0;
            field_f       <= 1'b0;
            s1_h          <= 1'b0;
            s1_y          <= '0;
            s1_cb         <= '0;
            s1_cr         <= '0;
            o_sync_h      <= 1'b0;
            o_sync_v      <= 1'b0;
            o_field       <= 1'b0;
            o_y           <= '0;
            o_cb          <= '0;
            o_cr          <= '0;
            o_line_len    <= '0;
            o_field_lines <= '0;
        end else begin
            hist0  <= i_y;
            hist1  <= hist0;
            hist2  <= hist1;
            to_cnt <= (xyz_ok || timeout) ? '0 : to_cnt + 1'b1;

            s1_h  <= active_in;
            s1_y  <= active_in ? i_y : '0;
            s1_cb <= !active_in ? '0 : (len_cnt[0] ? s1_cb : i_cbcr);
            s1_cr <= !active_in ? '0 : (len_cnt[0] ? i_cbcr : s1_cr);

            if (timeout) begin
                meas      <= 1'b0;
                act_lines <= 1'b0;
                line_cnt  <= '0;
                bad_line  <= 1'b0;
            end else begin
                if (meas && is_ones) begin
                    meas       <= 1'b0;
                    o_line_len <= len_cnt;
                    if (len_cnt != W_EXP)
                        bad_line <= 1'b1;
                end else if (meas && len_cnt != CNT_MAX) begin
                    len_cnt <= len_cnt + 1'b1;
                end
                if (sav && !xyz_v) begin
                    meas    <= 1'b1;
                    len_cnt <= '0;
                end
                if (xyz_ok) begin
                    act_lines <= !xyz_v;
                    field_f   <= xyz_f;
                end
                if (eav && !xyz_v && line_cnt != CNT_MAX)
                    line_cnt <= line_cnt + 1'b1;
                if (field_end) begin
                    o_field_lines <= line_cnt;
                    line_cnt      <= '0;
                    bad_line      <= 1'b0;
                end
            end

            o_sync_h <= s1_h;
            o_y      <= s1_y;
            o_cb     <= s1_cb;
            o_cr     <= s1_cr;
            o_sync_v <= act_lines;
            o_field  <= field_f;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        err_nxt   = o_err_count;
        if (timeout) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
            bad_nxt   = '0;
        end else if (field_end) begin
            case (state)
                SEARCH: begin
                    if (field_good) begin
                        good_nxt  = 8'd1;
                        state_nxt = (good_nxt >= LOCK_N) ? LOCKED : CHECK;
                    end
                end
                CHECK: begin
                    if (field_good) begin
                        good_nxt = good_cnt + 8'd1;
                        if (good_nxt >= LOCK_N)
                            state_nxt = LOCKED;
                    end else begin
                        good_nxt  = '0;
                        state_nxt = SEARCH;
                    end
                end
                LOCKED: begin
                    if (field_good) begin
                        bad_nxt = '0;
                    end else begin
                        bad_nxt = bad_cnt + 8'd1;
                        if (o_err_count != 8'hFF)
                            err_nxt = o_err_count + 8'd1;
                        if (bad_nxt >= ERR_N) begin
                            state_nxt = SEARCH;
                            good_nxt  = '0;
                            bad_nxt   = '0;
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= SEARCH;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            o_err_count <= '0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_nxt;
            bad_cnt     <= bad_nxt;
            o_err_count <= err_nxt;
        end
    end

    assign o_locked = (state == LOCKED);

endmodule

// File: tb/tb_sdi_timing_analyzer.sv
// Directed bench for sdi_timing_analyzer on a shrunk raster (16 samples x 4 active lines per field).
module tb_sdi_timing_analyzer;
    localparam int DW = 10, IMG_W = 16, IMG_H = 4, CNT_W = 12;
    localparam int LOCK_FIELDS = 2, ERR_FIELDS = 2, TRS_TIMEOUT = 200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DW-1:0]    y = '0;
    logic [DW-1:0]    cbcr = '0;
    logic             o_sync_h, o_sync_v, o_field, o_locked;
    logic [DW-1:0]    o_y, o_cb, o_cr;
    logic [CNT_W-1:0] o_line_len, o_field_lines;
    logic [7:0]       o_err_count;
    int vectors = 0;
    int errors = 0;

    sdi_timing_analyzer #(
        .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W),
        .LOCK_FIELDS(LOCK_FIELDS), .ERR_FIELDS(ERR_FIELDS), .TRS_TIMEOUT(TRS_TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_y(y), .i_cbcr(cbcr),
        .o_sync_h(o_sync_h), .o_sync_v(o_sync_v), .o_field(o_field),
        .o_y(o_y), .o_cb(o_cb), .o_cr(o_cr),
        .o_line_len(o_line_len), .o_field_lines(o_field_lines),
        .o_locked(o_locked), .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix(input int i);
        return 10'(10'h080 + i);
    endfunction

    function automatic logic [DW-1:0] cbv(input int i);
        return (i % 2 == 1) ? 10'(10'h200 + i / 2) : 10'(10'h100 + i / 2);
    endfunction

    function automatic logic [DW-1:0] xyz(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, 6'b0};
    endfunction

    // Inputs change just after a falling edge and are sampled on the next rising edge.
    task automatic send(input logic [DW-1:0] yv, input logic [DW-1:0] cv);
        y = yv;
        cbcr = cv;
        @(negedge clk);
    endtask

    task automatic trs(input logic f, input logic v, input logic h);
        send(10'h3FF, 10'h200);
        send(10'h000, 10'h200);
        send(10'h000, 10'h200);
        send(xyz(f, v, h), 10'h200);
    endtask

    task automatic line_tail(input logic f, input logic v, input int n);
        repeat (4) send(10'h040, 10'h200);
        trs(f, v, 1'b0);
        for (int i = 0; i < n; i++) send(pix(i), cbv(i));
    endtask

    task automatic line(input logic f, input logic v, input int n);
        trs(f, v, 1'b1);
        line_tail(f, v, n);
    endtask

    task automatic field(input logic f, input int short_idx);
        for (int k = 0; k < IMG_H; k++) line(f, 1'b0, (k == short_idx) ? IMG_W - 2 : IMG_W);
        line(f, 1'b1, IMG_W);
        line(f, 1'b1, IMG_W);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if ({o_sync_h, o_sync_v, o_field, o_locked} !== 4'b0) begin errors++; $display("FAIL reset_flags: h/v/f/lock=%b expected 0000", {o_sync_h, o_sync_v, o_field, o_locked}); end
        vectors++; if ({o_y, o_cb, o_cr} !== 30'd0) begin errors++; $display("FAIL reset_video: y=%h cb=%h cr=%h expected 0", o_y, o_cb, o_cr); end
        vectors++; if ({o_line_len, o_field_lines, o_err_count} !== 32'd0) begin errors++; $display("FAIL reset_meas: len=%0d lines=%0d err=%0d expected 0", o_line_len, o_field_lines, o_err_count); end
        rst = 1'b0;
    endtask

    task automatic test_clean_lock();
        field(1'b0, -1);
        vectors++; if (o_locked !== 1'b0) begin errors++; $display("FAIL lock_f1: o_locked=%b expected 0", o_locked); end
        vectors++; if (o_field_lines !== 12'd4) begin errors++; $display("FAIL lines_f1: got %0d expected 4", o_field_lines); end
        vectors++; if (o_line_len !== 12'd16) begin errors++; $display("FAIL len_f1: got %0d expected 16", o_line_len); end
        field(1'b1, -1);
        vectors++; if (o_locked !== 1'b1) begin errors++; $display("FAIL lock_f2: o_locked=%b expected 1", o_locked); end
        vectors++; if (o_field !== 1'b1) begin errors++; $display("FAIL field_f2: o_field=%b expected 1", o_field); end
        field(1'b0, -1);
        vectors++; if (o_locked !== 1'b1 || o_err_count !== 8'd0) begin errors++; $display("FAIL lock_f3: locked=%b err=%0d expected 1/0", o_locked, o_err_count); end
        vectors++; if (o_field !== 1'b0) begin errors++; $display("FAIL field_f3: o_field=%b expected 0", o_field); end
    endtask

    task automatic test_chroma_latency();
        for (int k = 0; k < IMG_H - 1; k++) line(1'b1, 1'b0, IMG_W);
        trs(1'b1, 1'b0, 1'b1);
        repeat (4) send(10'h040, 10'h200);
        trs(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < IMG_W; i++) begin
            send(pix(i), cbv(i));
            if (i == 0) begin
                vectors++; if (o_sync_h !== 1'b0 || o_y !== 10'h000) begin errors++; $display("FAIL pre_window: h=%b y=%h expected 0/000", o_sync_h, o_y); end
            end else begin
                vectors++; if (o_y !== pix(i - 1) || o_sync_h !== 1'b1 || o_sync_v !== 1'b1) begin errors++; $display("FAIL luma_px%0d: y=%h h=%b v=%b expected %h/1/1", i - 1, o_y, o_sync_h, o_sync_v, pix(i - 1)); end
                if ((i - 1) % 2 == 0) begin
                    vectors++; if (o_cb !== cbv(i - 1)) begin errors++; $display("FAIL cb_px%0d: got %h expected %h", i - 1, o_cb, cbv(i - 1)); end
                end else begin
                    vectors++; if (o_cr !== cbv(i - 1) || o_cb !== cbv(i - 2)) begin errors++; $display("FAIL cr_px%0d: cr=%h cb=%h expected %h/%h", i - 1, o_cr, o_cb, cbv(i - 1), cbv(i - 2)); end
                end
            end
        end
        send(10'h3FF, 10'h200);
        vectors++; if (o_y !== pix(IMG_W - 1) || o_cr !== cbv(IMG_W - 1)) begin errors++; $display("FAIL last_px: y=%h cr=%h expected %h/%h", o_y, o_cr, pix(IMG_W - 1), cbv(IMG_W - 1)); end
        send(10'h000, 10'h200);
        vectors++; if ({o_sync_h, o_y, o_cb, o_cr} !== 31'd0) begin errors++; $display("FAIL blank_chroma: h=%b y=%h cb=%h cr=%h expected 0", o_sync_h, o_y, o_cb, o_cr); end
        send(10'h000, 10'h200);
        send(xyz(1'b1, 1'b1, 1'b1), 10'h200);
        line_tail(1'b1, 1'b1, IMG_W);
        line(1'b1, 1'b1, IMG_W);
        vectors++; if (o_locked !== 1'b1 || o_field_lines !== 12'd4 || o_err_count !== 8'd0) begin errors++; $display("FAIL chroma_field: locked=%b lines=%0d err=%0d expected 1/4/0", o_locked, o_field_lines, o_err_count); end
    endtask

    task automatic test_bad_line();
        line(1'b0, 1'b0, IMG_W);
        line(1'b0, 1'b0, IMG_W - 2);
        trs(1'b0, 1'b0, 1'b1);
        vectors++; if (o_line_len !== 12'd14) begin errors++; $display("FAIL short_len: got %0d expected 14", o_line_len); end
        line_tail(1'b0, 1'b0, IMG_W);
        line(1'b0, 1'b0, IMG_W);
        line(1'b0, 1'b1, IMG_W);
        line(1'b0, 1'b1, IMG_W);
        vectors++; if (o_err_count !== 8'd1 || o_locked !== 1'b1) begin errors++; $display("FAIL bad_field1: err=%0d locked=%b expected 1/1", o_err_count, o_locked); end
        vectors++; if (o_field_lines !== 12'd4) begin errors++; $display("FAIL bad_field1_lines: got %0d expected 4", o_field_lines); end
        field(1'b1, 2);
        vectors++; if (o_err_count !== 8'd2 || o_locked !== 1'b0) begin errors++; $display("FAIL bad_field2: err=%0d locked=%b expected 2/0", o_err_count, o_locked); end
        field(1'b0, -1);
        vectors++; if (o_locked !== 1'b0) begin errors++; $display("FAIL relock_f1: o_locked=%b expected 0", o_locked); end
        field(1'b1, -1);
        vectors++; if (o_locked !== 1'b1 || o_err_count !== 8'd2) begin errors++; $display("FAIL relock_f2: locked=%b err=%0d expected 1/2", o_locked, o_err_count); end
    endtask

    task automatic test_malformed_timeout();
        int n;
        trs(1'b0, 1'b0, 1'b1);
        repeat (4) send(10'h040, 10'h200);
        trs(1'b0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < IMG_W; i++) begin send(pix(i), cbv(i)); n++; end
        while (n < TRS_TIMEOUT + 3) begin
            if (n == 40) send(10'h3FF, 10'h200);
            else if (n == 41 || n == 42) send(10'h000, 10'h200);
            else if (n == 43) send(10'h0B0, 10'h200);
            else send(10'h040, 10'h200);
            n++;
            if (n == 50) begin
                vectors++; if (o_sync_v !== 1'b1 || o_locked !== 1'b1 || o_field !== 1'b0) begin errors++; $display("FAIL malformed_xyz: v=%b locked=%b f=%b expected 1/1/0", o_sync_v, o_locked, o_field); end
            end
            if (n == TRS_TIMEOUT - 5) begin
                vectors++; if (o_locked !== 1'b1) begin errors++; $display("FAIL pre_timeout: o_locked=%b expected 1", o_locked); end
            end
        end
        vectors++; if (o_locked !== 1'b0) begin errors++; $display("FAIL timeout_lock: o_locked=%b expected 0", o_locked); end
        vectors++; if (o_sync_h !== 1'b0 || o_sync_v !== 1'b0) begin errors++; $display("FAIL timeout_sync: h=%b v=%b expected 0/0", o_sync_h, o_sync_v); end
        vectors++; if (o_err_count !== 8'd2) begin errors++; $display("FAIL timeout_err: got %0d expected 2", o_err_count); end
    endtask

    task automatic test_midline_reset();
        trs(1'b0, 1'b0, 1'b1);
        repeat (4) send(10'h040, 10'h200);
        trs(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(pix(i), cbv(i));
        vectors++; if (o_sync_h !== 1'b1 || o_y !== pix(3)) begin errors++; $display("FAIL pre_reset: h=%b y=%h expected 1/%h", o_sync_h, o_y, pix(3)); end
        rst = 1'b1;
        send(pix(5), cbv(5));
        rst = 1'b0;
        vectors++; if ({o_sync_h, o_sync_v, o_field, o_locked, o_y, o_cb, o_cr} !== 34'd0) begin errors++; $display("FAIL rst_video: h=%b v=%b y=%h cb=%h cr=%h expected 0", o_sync_h, o_sync_v, o_y, o_cb, o_cr); end
        vectors++; if ({o_line_len, o_field_lines, o_err_count} !== 32'd0) begin errors++; $display("FAIL rst_meas: len=%0d lines=%0d err=%0d expected 0", o_line_len, o_field_lines, o_err_count); end
        for (int i = 6; i < IMG_W; i++) begin
            send(pix(i), cbv(i));
            vectors++; if (o_sync_h !== 1'b0) begin errors++; $display("FAIL post_rst_px%0d: o_sync_h=%b expected 0", i, o_sync_h); end
        end
        line(1'b0, 1'b0, IMG_W);
        vectors++; if (o_sync_h !== 1'b1 || o_y !== pix(IMG_W - 2)) begin errors++; $display("FAIL resync: h=%b y=%h expected 1/%h", o_sync_h, o_y, pix(IMG_W - 2)); end
        vectors++; if (o_line_len !== 12'd0) begin errors++; $display("FAIL no_partial_len: got %0d expected 0", o_line_len); end
        trs(1'b0, 1'b0, 1'b1);
        vectors++; if (o_line_len !== 12'd16) begin errors++; $display("FAIL first_len: got %0d expected 16", o_line_len); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_chroma_latency();
        test_bad_line();
        test_malformed_timeout();
        test_midline_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
